// File: rtl/ac_zone_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ac_zone_scheduler_pkg
//  Purpose  : Shared constants for the AC zone scheduler: AC mode encodings
//             (common with the AC controller), default setpoint clamp limits,
//             scheduler FSM state encodings and small helper functions.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ac_zone_scheduler_pkg;

   // AC controller mode encodings
   localparam logic [1:0] MODE_OFF       = 2'b00;
   localparam logic [1:0] MODE_AUTOMATIC = 2'b01;
   localparam logic [1:0] MODE_FAST_COOL = 2'b10;
   localparam logic [1:0] MODE_ECO       = 2'b11;

   // Default setpoint clamp window
   localparam logic [6:0] MINTEMP_DEFAULT = 7'd18;
   localparam logic [6:0] MAXTEMP_DEFAULT = 7'd26;

   // Scheduler FSM state encoding
   localparam int         c_ST_W      = 2;
   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_SELECT = 2'd1;
   localparam logic [1:0] c_ST_RUN    = 2'd2;
   localparam logic [1:0] c_ST_GUARD  = 2'd3;

   function automatic logic [6:0] clamp_setpoint(input logic [6:0] sp,
                                                 input logic [6:0] lo,
                                                 input logic [6:0] hi);
      if (sp < lo)      return lo;
      else if (sp > hi) return hi;
      else              return sp;
   endfunction

   // Cooling demand (temp - setpoint) to AC mode; non-positive demand is OFF.
   function automatic logic [1:0] mode_from_delta(input logic signed [7:0] d);
      if (d >= 8'sd6)      return MODE_FAST_COOL;
      else if (d >= 8'sd3) return MODE_AUTOMATIC;
      else if (d >= 8'sd1) return MODE_ECO;
      else                 return MODE_OFF;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ac_zone_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : ac_zone_scheduler_if
//  Purpose  : Bundles the per-zone request bus and the AC/damper outputs.
//  Signals  : zone_req[NZONES], zone_setpoint[7*NZONES], zone_temp[7*NZONES]
//             (zone side -> scheduler); ac_mode[2], ac_setpoint[7],
//             zone_grant[NZONES], busy (scheduler -> AC/dampers).
//  Modports : master = zone/sensor side, slave = scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface ac_zone_scheduler_if #(
   parameter int NZONES = 4
);
   logic [NZONES-1:0]   zone_req;
   logic [7*NZONES-1:0] zone_setpoint;
   logic [7*NZONES-1:0] zone_temp;
   logic [1:0]          ac_mode;
   logic [6:0]          ac_setpoint;
   logic [NZONES-1:0]   zone_grant;
   logic                busy;

   modport master (
      output zone_req, zone_setpoint, zone_temp,
      input  ac_mode, ac_setpoint, zone_grant, busy
   );

   modport slave (
      input  zone_req, zone_setpoint, zone_temp,
      output ac_mode, ac_setpoint, zone_grant, busy
   );
endinterface
`default_nettype wire

// File: rtl/ac_zone_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : zone_rr_arbiter
//  Purpose  : Combinational round-robin pick: first asserted req at or after
//             ptr, wrapping past NZONES-1 back to zone 0.
//  Ports    : req[NZONES] in, ptr[PTR_W] in, winner[PTR_W] out, valid out
//  Revision : 1.0  initial release
// ============================================================================
module zone_rr_arbiter #(
   parameter int NZONES = 4,
   parameter int PTR_W  = 2
) (
   input  wire logic [NZONES-1:0] req,
   input  wire logic [PTR_W-1:0]  ptr,
   output logic      [PTR_W-1:0]  winner,
   output logic                   valid
);

   logic [PTR_W:0] w_idx;

   // Scan from the farthest offset down so the nearest request to ptr wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      w_idx  = '0;
      for (int k = NZONES - 1; k >= 0; k--) begin
         w_idx = {1'b0, ptr} + (PTR_W+1)'(k);
         if (w_idx >= (PTR_W+1)'(NZONES))
            w_idx = w_idx - (PTR_W+1)'(NZONES);
         if (req[w_idx[PTR_W-1:0]]) begin
            valid  = 1'b1;
            winner = w_idx[PTR_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ac_zone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ac_zone_scheduler
//  Purpose  : Time-shares one AC unit among NZONES rooms. Zones are granted
//             round-robin for up to DWELL_CYCLES, each grant followed by
//             GUARD_CYCLES with the AC off. All outputs are registered.
//  Ports    : clk          in   system clock (rising edge)
//             reset        in   asynchronous, active-low reset
//             bus (slave)  zone_req/zone_setpoint/zone_temp in,
//                          ac_mode/ac_setpoint/zone_grant/busy out
//  Revision : 1.0  initial release
// ============================================================================
module ac_zone_scheduler
   import ac_zone_scheduler_pkg::*;
#(
   parameter int         NZONES       = 4,
   parameter int         DWELL_CYCLES = 1000,
   parameter int         GUARD_CYCLES = 100,
   parameter logic [6:0] MINTEMP      = MINTEMP_DEFAULT,
   parameter logic [6:0] MAXTEMP      = MAXTEMP_DEFAULT
) (
   input wire logic           clk,
   input wire logic           reset,
   ac_zone_scheduler_if.slave bus
);

   localparam int c_PTR_W   = (NZONES > 1) ? $clog2(NZONES) : 1;
   localparam int c_CNT_MAX = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD_CYCLES - 1);

   logic [c_ST_W-1:0]  r_state, w_state_nxt;
   logic [c_PTR_W-1:0] r_ptr, w_ptr_nxt;
   logic [c_PTR_W-1:0] r_winner, w_winner_nxt;
   logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [1:0]         r_mode, w_mode_nxt;
   logic [6:0]         r_sp, w_sp_nxt;
   logic [NZONES-1:0]  r_grant, w_grant_nxt;
   logic               r_busy, w_busy_nxt;

   logic [c_PTR_W-1:0] w_arb_winner;
   logic               w_arb_valid;
   logic [6:0]         w_sel_raw, w_sel_temp, w_sel_sp;
   logic signed [7:0]  w_sel_delta;
   logic               w_sel_hot;

   zone_rr_arbiter #(
      .NZONES (NZONES),
      .PTR_W  (c_PTR_W)
   ) u_arb (
      .req    (bus.zone_req),
      .ptr    (r_ptr),
      .winner (w_arb_winner),
      .valid  (w_arb_valid)
   );

   // Candidate zone's clamped setpoint and cooling demand (exact in 8 bits).
   assign w_sel_raw   = bus.zone_setpoint[7*int'(w_arb_winner) +: 7];
   assign w_sel_temp  = bus.zone_temp[7*int'(w_arb_winner) +: 7];
   assign w_sel_sp    = clamp_setpoint(w_sel_raw, MINTEMP, MAXTEMP);
   assign w_sel_delta = $signed({1'b0, w_sel_temp} - {1'b0, w_sel_sp});
   assign w_sel_hot   = (w_sel_delta > 8'sd0);
   assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= c_ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:   if (|bus.zone_req) w_state_nxt = c_ST_SELECT;
         c_ST_SELECT: w_state_nxt = (w_arb_valid && w_sel_hot) ? c_ST_RUN : c_ST_IDLE;
         c_ST_RUN:    if (r_cnt == c_DWELL_LAST || !bus.zone_req[r_winner])
                         w_state_nxt = c_ST_GUARD;
         c_ST_GUARD:  if (r_cnt == c_GUARD_LAST) w_state_nxt = c_ST_IDLE;
         default:     w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Output/datapath logic: values the registers take at the next edge.
   always_comb begin
      w_mode_nxt   = MODE_OFF;
      w_grant_nxt  = '0;
      w_sp_nxt     = r_sp;
      w_ptr_nxt    = r_ptr;
      w_winner_nxt = r_winner;
      w_cnt_nxt    = '0;
      w_busy_nxt   = (w_state_nxt != c_ST_IDLE);
      case (r_state)
         c_ST_SELECT: begin
            // The pointer advances past the winner even when it is skipped.
            if (w_arb_valid) begin
               w_ptr_nxt    = (w_arb_winner == c_PTR_W'(NZONES - 1)) ? '0 : w_arb_winner + 1'b1;
               w_winner_nxt = w_arb_winner;
            end
            if (w_state_nxt == c_ST_RUN) begin
               w_mode_nxt  = mode_from_delta(w_sel_delta);
               w_sp_nxt    = w_sel_sp;
               w_grant_nxt = NZONES'(1) << w_arb_winner;
            end
         end
         c_ST_RUN: begin
            if (w_state_nxt == c_ST_RUN) begin
               w_mode_nxt  = r_mode;
               w_grant_nxt = r_grant;
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         c_ST_GUARD: begin
            if (w_state_nxt == c_ST_GUARD) w_cnt_nxt = w_cnt_inc;
         end
         default: ;
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr    <= '0;
         r_winner <= '0;
         r_cnt    <= '0;
         r_mode   <= MODE_OFF;
         r_sp     <= MINTEMP;
         r_grant  <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_ptr    <= w_ptr_nxt;
         r_winner <= w_winner_nxt;
         r_cnt    <= w_cnt_nxt;
         r_mode   <= w_mode_nxt;
         r_sp     <= w_sp_nxt;
         r_grant  <= w_grant_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign bus.ac_mode     = r_mode;
   assign bus.ac_setpoint = r_sp;
   assign bus.zone_grant  = r_grant;
   assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ac_zone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ac_zone_scheduler
//  Purpose  : Self-checking bench for ac_zone_scheduler: directed scenarios
//             with literal expectations plus randomized requests checked
//             every cycle against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ac_zone_scheduler;

   localparam int NZ    = 4;
   localparam int DWELL = 12;
   localparam int GUARD = 5;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ac_zone_scheduler_if #(.NZONES(NZ)) bus ();

   ac_zone_scheduler #(
      .NZONES       (NZ),
      .DWELL_CYCLES (DWELL),
      .GUARD_CYCLES (GUARD),
      .MINTEMP      (7'd18),
      .MAXTEMP      (7'd26)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_PICK, M_SERVE, M_REST} mph_t;
   mph_t ph = M_IDLE;
   int   m_next = 0, m_cur = 0, m_left = 0, m_mode = 0, e_sp = 18;
   int   pick_w, pick_sp, pick_d;
   logic [NZ-1:0] e_grant;
   int   e_mode;
   logic e_busy;

   function automatic int first_req(input logic [NZ-1:0] r, input int start);
      for (int k = 0; k < NZ; k++)
         if (r[(start + k) % NZ]) return (start + k) % NZ;
      return -1;
   endfunction

   function automatic int field(input logic [7*NZ-1:0] v, input int z);
      logic [6:0] f;
      f = v[7*z +: 7];
      return int'(f);
   endfunction

   function automatic int clampi(input int v);
      return (v < 18) ? 18 : ((v > 26) ? 26 : v);
   endfunction

   function automatic int mode_of(input int d);
      if (d >= 6) return 2;
      if (d >= 3) return 1;
      if (d >= 1) return 3;
      return 0;
   endfunction

   always_comb begin
      pick_w  = first_req(bus.zone_req, m_next);
      pick_sp = 0;
      pick_d  = 0;
      if (pick_w >= 0) begin
         pick_sp = clampi(field(bus.zone_setpoint, pick_w));
         pick_d  = field(bus.zone_temp, pick_w) - pick_sp;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph <= M_IDLE; m_next <= 0; m_cur <= 0; m_left <= 0; m_mode <= 0; e_sp <= 18;
      end else begin
         case (ph)
            M_IDLE: if (bus.zone_req != '0) ph <= M_PICK;
            M_PICK: begin
               if (pick_w < 0) ph <= M_IDLE;
               else begin
                  m_next <= (pick_w + 1) % NZ;
                  if (pick_d <= 0) ph <= M_IDLE;
                  else begin
                     ph <= M_SERVE; m_cur <= pick_w; m_mode <= mode_of(pick_d);
                     e_sp <= pick_sp; m_left <= DWELL - 1;
                  end
               end
            end
            M_SERVE: begin
               if (m_left == 0 || !bus.zone_req[m_cur]) begin
                  ph <= M_REST; m_left <= GUARD - 1;
               end else m_left <= m_left - 1;
            end
            default: begin
               if (m_left == 0) ph <= M_IDLE;
               else m_left <= m_left - 1;
            end
         endcase
      end
   end

   assign e_grant = (ph == M_SERVE) ? NZ'(1 << m_cur) : '0;
   assign e_mode  = (ph == M_SERVE) ? m_mode : 0;
   assign e_busy  = (ph != M_IDLE);

   // Per-cycle compare, away from the active edge
   always @(negedge clk) begin
      chk("cyc_mode",  32'(bus.ac_mode),     32'(e_mode));
      chk("cyc_sp",    32'(bus.ac_setpoint), 32'(e_sp));
      chk("cyc_grant", 32'(bus.zone_grant),  32'(e_grant));
      chk("cyc_busy",  32'(bus.busy),        32'(e_busy));
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_zone(input int z, input logic r, input int sp, input int t);
      bus.zone_req[z] = r;
      bus.zone_setpoint[7*z +: 7] = 7'(sp);
      bus.zone_temp[7*z +: 7]     = 7'(t);
   endtask

   task automatic wait_grant(input string nm, input logic [NZ-1:0] want);
      int n = 0;
      while (bus.zone_grant === '0 && n < 200) begin @(negedge clk); n++; end
      chk(nm, 32'(bus.zone_grant), 32'(want));
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (bus.busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      chk(nm, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int n, g, k;
      logic [NZ-1:0] prev;
      logic [NZ-1:0] seq [5];
      logic [NZ-1:0] want_seq [5];

      rst_n = 1'b0;
      bus.zone_req = '0; bus.zone_setpoint = '0; bus.zone_temp = '0;
      repeat (3) @(negedge clk);
      chk("rst_mode",  32'(bus.ac_mode), 32'd0);
      chk("rst_sp",    32'(bus.ac_setpoint), 32'd18);
      chk("rst_grant", 32'(bus.zone_grant), 32'd0);
      chk("rst_busy",  32'(bus.busy), 32'd0);
      rst_n = 1'b1;

      // All four zones, d=4 each: strict rotation from zone 0, mode AUTOMATIC
      @(negedge clk);
      for (int z = 0; z < NZ; z++) set_zone(z, 1'b1, 20, 24);
      want_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      prev = '0; k = 0; n = 0;
      while (k < 5 && n < 400) begin
         @(negedge clk); n++;
         if (bus.zone_grant !== '0 && prev === '0) begin
            seq[k] = bus.zone_grant;
            chk("rot_mode", 32'(bus.ac_mode), 32'd1);
            k++;
         end
         prev = bus.zone_grant;
      end
      chk("rot_count", 32'(k), 32'd5);
      for (int i = 0; i < 5; i++) chk("rot_order", 32'(seq[i]), 32'(want_seq[i]));
      for (int z = 0; z < NZ; z++) set_zone(z, 1'b0, 20, 24);
      wait_idle("rot_idle");

      // Zone 1 alone, d=8: latency, dwell length, guard length
      @(negedge clk);
      set_zone(1, 1'b1, 22, 30);
      @(negedge clk);
      chk("t2_sel_grant", 32'(bus.zone_grant), 32'd0);
      chk("t2_sel_busy",  32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("t2_grant", 32'(bus.zone_grant), 32'b0010);
      chk("t2_mode",  32'(bus.ac_mode), 32'd2);
      chk("t2_sp",    32'(bus.ac_setpoint), 32'd22);
      chk("t2_model_grant", 32'(e_grant), 32'b0010);
      n = 0;
      while (bus.zone_grant === 4'b0010 && n < 100) begin n++; @(negedge clk); end
      chk("t2_dwell", 32'(n), 32'(DWELL));
      set_zone(1, 1'b0, 22, 30);
      g = 0;
      while (bus.busy === 1'b1 && bus.zone_grant === '0 && g < 100) begin g++; @(negedge clk); end
      chk("t2_guard", 32'(g), 32'(GUARD));
      chk("t2_idle",  32'(bus.busy), 32'd0);

      // Setpoint clamping, low and high
      set_zone(0, 1'b1, 10, 20);
      wait_grant("t4a_grant", 4'b0001);
      chk("t4a_sp",   32'(bus.ac_setpoint), 32'd18);
      chk("t4a_mode", 32'(bus.ac_mode), 32'd3);
      chk("t4a_model_sp", 32'(e_sp), 32'd18);
      set_zone(0, 1'b0, 10, 20);
      wait_idle("t4a_idle");
      set_zone(0, 1'b1, 40, 27);
      wait_grant("t4b_grant", 4'b0001);
      chk("t4b_sp",   32'(bus.ac_setpoint), 32'd26);
      chk("t4b_mode", 32'(bus.ac_mode), 32'd3);
      set_zone(0, 1'b0, 40, 27);
      wait_idle("t4b_idle");

      // Zone 3 with d=0 is skipped; pointer then wraps to zone 0
      @(negedge clk);
      set_zone(3, 1'b1, 21, 21);
      g = 0;
      repeat (8) begin @(negedge clk); if (bus.zone_grant !== '0) g++; end
      chk("t5_nogrant", 32'(g), 32'd0);
      set_zone(3, 1'b0, 21, 21);
      wait_idle("t5_idle");
      @(negedge clk);
      set_zone(0, 1'b1, 20, 24);
      set_zone(1, 1'b1, 20, 24);
      wait_grant("t5_wrap", 4'b0001);
      set_zone(0, 1'b0, 20, 24);
      set_zone(1, 1'b0, 20, 24);
      wait_idle("t5_idle2");

      // Zone 2 drops its request in RUN cycle 5: guard follows, full length
      set_zone(2, 1'b1, 20, 30);
      wait_grant("t6_grant", 4'b0100);
      repeat (5) @(negedge clk);
      set_zone(2, 1'b0, 20, 30);
      @(negedge clk);
      chk("t6_grant_off", 32'(bus.zone_grant), 32'd0);
      chk("t6_busy", 32'(bus.busy), 32'd1);
      g = 0;
      while (bus.busy === 1'b1 && g < 100) begin g++; @(negedge clk); end
      chk("t6_guard", 32'(g), 32'(GUARD));

      // Async reset mid-RUN on zone 2; pointer returns to zone 0
      set_zone(2, 1'b1, 20, 24);
      wait_grant("t1_grant", 4'b0100);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_mode",  32'(bus.ac_mode), 32'd0);
      chk("t1_sp",    32'(bus.ac_setpoint), 32'd18);
      chk("t1_grant", 32'(bus.zone_grant), 32'd0);
      chk("t1_busy",  32'(bus.busy), 32'd0);
      chk("t1_model_busy", 32'(e_busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_zone(2, 1'b0, 20, 24);
      set_zone(0, 1'b1, 20, 24);
      set_zone(3, 1'b1, 20, 24);
      wait_grant("t1_ptr0", 4'b0001);
      set_zone(0, 1'b0, 20, 24);
      set_zone(3, 1'b0, 20, 24);
      wait_idle("t1_idle");

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c == 1500) begin #2 rst_n = 1'b0; #1 rst_n = 1'b1; end
         for (int z = 0; z < NZ; z++) begin
            if ($urandom_range(0, 11) == 0) bus.zone_req[z] = ~bus.zone_req[z];
            if ($urandom_range(0, 7) == 0) begin
               bus.zone_setpoint[7*z +: 7] = 7'($urandom_range(10, 34));
               bus.zone_temp[7*z +: 7]     = 7'($urandom_range(14, 40));
            end
         end
      end
      bus.zone_req = '0;
      repeat (DWELL + GUARD + 4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
